// File: rtl/scan_chain_ctrl.sv
// Scan test controller: loads a stimulus into a scan chain, runs a functional capture
// window, unloads the response and compares it to an expected value under a care mask.
module scan_chain_ctrl #(
    parameter int unsigned CHAIN_LEN      = 4,
    parameter int unsigned CAPTURE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic [CHAIN_LEN-1:0] care_mask,
    input  logic                 scan_out,
    output logic                 SE,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] response,
    output logic [7:0]           fail_count
);

    localparam int unsigned BitW = $clog2(CHAIN_LEN) + 1;
    localparam int unsigned CapW = $clog2(CAPTURE_CYCLES) + 1;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLoad    = 3'd1;
    localparam logic [2:0] StCapture = 3'd2;
    localparam logic [2:0] StUnload  = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CHAIN_LEN-1:0] shift_q, shift_d;
    logic [CHAIN_LEN-1:0] expected_q, expected_d;
    logic [CHAIN_LEN-1:0] mask_q, mask_d;
    logic [CHAIN_LEN-1:0] response_q, response_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CapW-1:0]      cap_cnt_q, cap_cnt_d;
    logic                 se_q, se_d;
    logic                 scan_in_q, scan_in_d;
    logic                 pass_q, pass_d;
    logic [7:0]           fail_count_q, fail_count_d;
    logic                 last_bit;
    logic                 last_cap;

    assign last_bit = (bit_cnt_q == BitW'(CHAIN_LEN - 1));
    assign last_cap = (cap_cnt_q == CapW'(CAPTURE_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        expected_d   = expected_q;
        mask_d       = mask_q;
        response_d   = response_q;
        bit_cnt_d    = bit_cnt_q;
        cap_cnt_d    = cap_cnt_q;
        se_d         = se_q;
        scan_in_d    = scan_in_q;
        pass_d       = pass_q;
        fail_count_d = fail_count_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d    = pattern_in;
                    expected_d = expected;
                    mask_d     = care_mask;
                    bit_cnt_d  = '0;
                    scan_in_d  = pattern_in[CHAIN_LEN-1];
                    se_d       = 1'b1;
                    pass_d     = 1'b0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (last_bit) begin
                    se_d      = 1'b0;
                    scan_in_d = 1'b0;
                    cap_cnt_d = '0;
                    state_d   = StCapture;
                end else begin
                    // MSB already presented; rotate so the next lower bit sits at the top-1.
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    scan_in_d = shift_q[CHAIN_LEN-2];
                    shift_d   = {shift_q[CHAIN_LEN-2:0], shift_q[CHAIN_LEN-1]};
                end
            end
            StCapture: begin
                if (last_cap) begin
                    se_d      = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = StUnload;
                end else begin
                    cap_cnt_d = cap_cnt_q + 1'b1;
                end
            end
            StUnload: begin
                // scan_out is the pre-shift Q of the last flop, so it lands in the LSB.
                response_d = {response_q[CHAIN_LEN-2:0], scan_out};
                if (last_bit) begin
                    se_d    = 1'b0;
                    pass_d  = ~|((response_d ^ expected_q) & mask_q);
                    state_d = StDone;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (!pass_q && (fail_count_q != 8'hFF)) begin
                    fail_count_d = fail_count_q + 8'd1;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            expected_q   <= '0;
            mask_q       <= '0;
            response_q   <= '0;
            bit_cnt_q    <= '0;
            cap_cnt_q    <= '0;
            se_q         <= 1'b0;
            scan_in_q    <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            expected_q   <= expected_d;
            mask_q       <= mask_d;
            response_q   <= response_d;
            bit_cnt_q    <= bit_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            se_q         <= se_d;
            scan_in_q    <= scan_in_d;
            pass_q       <= pass_d;
            fail_count_q <= fail_count_d;
        end
    end

    assign SE         = se_q;
    assign scan_in    = scan_in_q;
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign pass       = pass_q;
    assign response   = response_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: a 4-bit scan-enabled counter acts as the chain, and a
// scoreboard queue holds the expected response/pass for every started pattern.
module tb_scan_chain_ctrl;

    localparam int unsigned N   = 4;
    localparam int unsigned CAP = 1;

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] pattern_in;
    logic [N-1:0] expected;
    logic [N-1:0] care_mask;
    logic         scan_out;
    logic         SE;
    logic         scan_in;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N-1:0] response;
    logic [7:0]   fail_count;

    scan_chain_ctrl #(
        .CHAIN_LEN      (N),
        .CAPTURE_CYCLES (CAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern_in (pattern_in),
        .expected   (expected),
        .care_mask  (care_mask),
        .scan_out   (scan_out),
        .SE         (SE),
        .scan_in    (scan_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .response   (response),
        .fail_count (fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain under test: shift when SE=1, count up otherwise.
    logic [N-1:0] chain = '0;
    always @(posedge clk) begin
        if (SE) chain <= {chain[N-2:0], scan_in};
        else    chain <= chain + 4'd1;
    end
    assign scan_out = chain[N-1];

    typedef struct packed {
        logic [N-1:0] resp;
        logic         pass;
    } exp_t;

    exp_t sb_q[$];
    int   checks        = 0;
    int   errors        = 0;
    int   done_count    = 0;
    int   cyc           = 0;
    int   last_done_cyc = -1;
    bit   spacing_on    = 1'b0;
    bit   fc_pending    = 1'b0;
    int   exp_fail      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] p, input logic [N-1:0] e, input logic [N-1:0] m);
        exp_t x;
        x.resp = p + 4'(CAP);
        x.pass = (((x.resp ^ e) & m) == '0);
        sb_q.push_back(x);
    endtask

    // Drives a one-cycle start and returns at the falling edge of cycle 0.
    task automatic run_pattern(input logic [N-1:0] p, input logic [N-1:0] e,
                               input logic [N-1:0] m);
        @(negedge clk);
        start      = 1'b1;
        pattern_in = p;
        expected   = e;
        care_mask  = m;
        push_exp(p, e, m);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", done, 1);
        @(negedge clk);
    endtask

    // Scoreboard / result monitor.
    always @(negedge clk) begin
        exp_t x;
        cyc++;
        if (fc_pending) begin
            check("fail_count", fail_count, exp_fail);
            fc_pending = 1'b0;
        end
        if (done) begin
            check("sb_nonempty", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                x = sb_q.pop_front();
                check("response", response, x.resp);
                check("pass", pass, x.pass);
                if (!x.pass && exp_fail < 255) exp_fail++;
                fc_pending = 1'b1;
            end
            if (spacing_on && last_done_cyc >= 0) check("done_spacing", cyc - last_done_cyc, 11);
            last_done_cyc = cyc;
            done_count++;
        end
    end

    initial begin
        logic [10:0] se_prof;
        int          base;
        int          target;
        int          n;

        reset      = 1'b0;
        start      = 1'b0;
        pattern_in = '0;
        expected   = '0;
        care_mask  = '0;
        repeat (3) @(negedge clk);
        check("rst_se", SE, 0);
        check("rst_scan_in", scan_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_response", response, 0);
        check("rst_fail_count", fail_count, 0);
        reset = 1'b1;

        // Increment with full SE/busy/done profile.
        run_pattern(4'b1010, 4'b1011, 4'b1111);
        se_prof = 11'b00111101111;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            check("se_profile", SE, se_prof[k]);
            check("busy_profile", busy, (k <= 9));
            check("done_profile", done, (k == 9));
        end
        check("fc_after_pass", fail_count, 0);

        run_pattern(4'b1111, 4'b0000, 4'b1111);
        wait_done();

        run_pattern(4'b1010, 4'b0000, 4'b1111);
        wait_done();
        check("fc_after_fail", fail_count, 1);

        run_pattern(4'b0011, 4'b0000, 4'b1000);
        wait_done();

        run_pattern(4'b0000, 4'b1111, 4'b0000);
        wait_done();

        // Start pulse while busy must be ignored.
        base = done_count;
        run_pattern(4'b0101, 4'b0110, 4'b1111);
        repeat (3) @(negedge clk);
        check("busy_cycle3", busy, 1);
        start      = 1'b1;
        pattern_in = 4'b1100;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("single_done", done_count - base, 1);

        // Reset in cycle 6 aborts the pattern.
        base = done_count;
        run_pattern(4'b0110, 4'b0111, 4'b1111);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_se", SE, 0);
        check("abort_scan_in", scan_in, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pass", pass, 0);
        check("abort_response", response, 0);
        check("abort_fail_count", fail_count, 0);
        reset = 1'b1;
        sb_q.delete();
        exp_fail = 0;
        repeat (20) @(negedge clk);
        check("no_done_after_abort", done_count - base, 0);

        // Saturation: 260 failing patterns back-to-back.
        spacing_on    = 1'b1;
        last_done_cyc = -1;
        target        = done_count + 260;
        for (int i = 0; i < 260; i++) push_exp(4'b1010, 4'b0000, 4'b1111);
        @(negedge clk);
        start      = 1'b1;
        pattern_in = 4'b1010;
        expected   = 4'b0000;
        care_mask  = 4'b1111;
        n = 0;
        while (done_count < target && n < 260 * 11 + 100) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("b2b_timeout", (done_count >= target), 1);
        repeat (3) @(negedge clk);
        spacing_on = 1'b0;
        check("fc_saturated", fail_count, 255);
        check("sb_drained", sb_q.size(), 0);
        check("idle_at_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
